// File: rtl/bridge_rsp_if.sv
// Writer/reader handshake bundle for the bridge responder.
// master = requesting side, slave = bridge_rsp.
interface bridge_rsp_if;
    logic       wr_valid;
    logic [1:0] wr_data;
    logic       wr_ready;
    logic       rd_req;
    logic [1:0] rd_data;
    logic       rd_valid;

    modport master (
        output wr_valid, wr_data, rd_req,
        input  wr_ready, rd_data, rd_valid
    );

    modport slave (
        input  wr_valid, wr_data, rd_req,
        output wr_ready, rd_data, rd_valid
    );
endinterface

// File: rtl/bridge_rsp.sv
// Bridge responder: small FIFO with a one-cycle read-response FSM.
// Optional sticky overflow flag via BRIDGE_RSP_OVF_FLAG_EN.
module bridge_rsp #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    bridge_rsp_if.slave              bus,
    output logic [$clog2(DEPTH):0]   count
`ifdef BRIDGE_RSP_OVF_FLAG_EN
    ,
    output logic                     ovf
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE,
        STALL,
        RESP
    } state_t;

    state_t          r_state;
    logic [1:0]      r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_wr_ready;
    logic            r_rd_valid;
    logic [1:0]      r_rd_data;

    logic            w_wr_acc;
    logic            w_nonempty;
    logic            w_pop;
    logic [CW-1:0]   w_count_next;

    assign w_wr_acc   = bus.wr_valid & r_wr_ready;
    assign w_nonempty = (r_count != '0);

    always_comb begin
        w_pop = 1'b0;
        unique case (r_state)
            IDLE:    w_pop = bus.rd_req & w_nonempty;
            STALL:   w_pop = w_nonempty;
            default: w_pop = 1'b0;
        endcase
    end

    assign w_count_next = r_count
                        + {{PW{1'b0}}, w_wr_acc}
                        - {{PW{1'b0}}, w_pop};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_wr_ready <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= 2'b00;
        end else begin
            if (w_wr_acc) begin
                r_mem[r_wr_ptr] <= bus.wr_data;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            r_count    <= w_count_next;
            // ready tracks next occupancy so a full FIFO blocks the very next write
            r_wr_ready <= (w_count_next < CW'(DEPTH));
            r_rd_valid <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (bus.rd_req)
                        r_state <= w_nonempty ? RESP : STALL;
                end
                STALL: begin
                    if (w_nonempty)
                        r_state <= RESP;
                end
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
            if (w_pop) begin
                r_rd_data  <= r_mem[r_rd_ptr];
                r_rd_ptr   <= r_rd_ptr + PW'(1);
                r_rd_valid <= 1'b1;
            end
        end
    end

`ifdef BRIDGE_RSP_OVF_FLAG_EN
    logic r_ovf;

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_ovf <= 1'b0;
        else if (bus.wr_valid && !r_wr_ready)
            r_ovf <= 1'b1;
    end

    assign ovf = r_ovf;
`endif

    assign bus.wr_ready = r_wr_ready;
    assign bus.rd_valid = r_rd_valid;
    assign bus.rd_data  = r_rd_data;
    assign count        = r_count;
endmodule
